// File: rtl/prg_loader.sv
// prg_loader: sequences a PRG file download into VIC-20 memory.
//   Parses the 2-byte load-address header from the data_io byte stream, issues
//   one handshaked write per payload byte (block RAM or SDRAM routing), then
//   writes the end address into the BASIC pointer bytes.
// Ports:
//   clk_sys, reset          - clock, synchronous active-high reset
//   dl_active/dl_wr         - download window and per-byte strobe
//   dl_addr/dl_data         - byte offset within file and byte value
//   wr_req/wr_addr/wr_data  - memory write request (held until wr_ack)
//   wr_int                  - 1 = internal RAM, 0 = SDRAM
//   wr_ack                  - one-cycle write completion
//   busy/done/overflow      - loader owns write path / end pulse / dropped byte
//   end_addr                - load address + payload count (mod 2^16)
module prg_loader #(
  parameter int unsigned NUM_PTR = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        wr_req,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_int,
  input  logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] end_addr
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_INJECT, S_FIN} state_t;

  state_t      state_q, state_d;
  logic        act_q;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] end_q, end_d;
  logic [3:0]  idx_q, idx_d;
  // slot = byte currently owned by the write port; buf = one-deep holding buffer
  logic        slot_v_q, slot_v_d;
  logic        buf_v_q, buf_v_d;
  logic [15:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        wr_req_q, wr_req_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_int_q, wr_int_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        ack;

  function automatic logic is_int(input logic [15:0] a);
    return (a[15:10] == 6'b000000) || (a[15:11] == 5'b00010) ||
           (a[15:11] == 5'b00011)  || (a[15:10] == 6'b100101);
  endfunction

  function automatic logic [15:0] ptr_addr(input logic [3:0] i);
    case (i)
      4'd0:    return 16'h002D;
      4'd1:    return 16'h002E;
      4'd2:    return 16'h002F;
      4'd3:    return 16'h0030;
      4'd4:    return 16'h0031;
      4'd5:    return 16'h0032;
      4'd6:    return 16'h00AE;
      4'd7:    return 16'h00AF;
      default: return 16'h0000;
    endcase
  endfunction

  assign ack = wr_req_q & wr_ack;

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    end_d      = end_q;
    idx_d      = idx_q;
    slot_v_d   = slot_v_q;
    buf_v_d    = buf_v_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_int_d   = wr_int_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (dl_active && !act_q) begin
          state_d = S_HDR;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          end_d   = '0;
        end
      end

      S_HDR: begin
        if (!dl_active) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (dl_wr && dl_addr == 16'd0) begin
          lo_d = dl_data;
        end else if (dl_wr && dl_addr == 16'd1) begin
          end_d   = {dl_data, lo_q};
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        // Retire the acked byte first so a same-cycle dl_wr sees the freed space.
        if (ack) begin
          if (buf_v_q) begin
            wr_addr_d = buf_addr_q;
            wr_data_d = buf_data_q;
            wr_int_d  = is_int(buf_addr_q);
            buf_v_d   = 1'b0;
          end else begin
            slot_v_d = 1'b0;
          end
        end
        if (dl_wr && dl_addr >= 16'd2) begin
          end_d = end_q + 16'd1;
          if (!slot_v_d) begin
            slot_v_d  = 1'b1;
            wr_addr_d = end_q;
            wr_data_d = dl_data;
            wr_int_d  = is_int(end_q);
          end else if (!buf_v_d) begin
            buf_v_d    = 1'b1;
            buf_addr_d = end_q;
            buf_data_d = dl_data;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!dl_active && !slot_v_d && !buf_v_d) begin
          state_d = S_INJECT;
          idx_d   = '0;
        end
      end

      S_INJECT: begin
        if (ack) begin
          slot_v_d = 1'b0;
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'(NUM_PTR - 1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (!slot_v_q) begin
          slot_v_d  = 1'b1;
          wr_addr_d = ptr_addr(idx_q);
          wr_data_d = idx_q[0] ? end_q[15:8] : end_q[7:0];
          wr_int_d  = is_int(ptr_addr(idx_q));
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Dropping the request on ack forces the mandatory low cycle between writes.
    wr_req_d = slot_v_d & ~ack;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      act_q      <= 1'b0;
      lo_q       <= '0;
      end_q      <= '0;
      idx_q      <= '0;
      slot_v_q   <= 1'b0;
      buf_v_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_int_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= dl_active;
      lo_q       <= lo_d;
      end_q      <= end_d;
      idx_q      <= idx_d;
      slot_v_q   <= slot_v_d;
      buf_v_q    <= buf_v_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      wr_req_q   <= wr_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_int_q   <= wr_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_req   = wr_req_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_int   = wr_int_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign end_addr = end_q;

endmodule
